busio_seq: RTL and testbench

BUSIO_SEQ -- requirements
Module: busio_seq

---
 rtl/busio_seq_if.sv | 27 ++
 rtl/busio_seq.sv | 127 ++++++++++++
 tb/tb_busio_seq.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/busio_seq_if.sv
// Bus-cycle sequencer interface: requester/slave inputs and the bus strobes.
// The sequencer (bus master) takes the master modport; the environment takes slave.
interface busio_seq_if;
    logic dati;
    logic dato;
    logic rmw;
    logic b;
    logic rply;
    logic sync;
    logic din;
    logic dout;
    logic wtbt;
    logic bsy;
    logic latch;
    logic complete;
    logic berror;

    modport master (
        input  dati, dato, rmw, b, rply,
        output sync, din, dout, wtbt, bsy, latch, complete, berror
    );

    modport slave (
        output dati, dato, rmw, b, rply,
        input  sync, din, dout, wtbt, bsy, latch, complete, berror
    );
endinterface

// File: rtl/busio_seq.sv
// Bus-cycle sequencer: read, write and read-modify-write cycles with an
// optional setup phase and a reply timeout that ends the cycle with berror.
module busio_seq #(
    parameter int unsigned SETUP = 1,
    parameter int unsigned TMO_W = 6,
    parameter int unsigned TMO   = 63
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_ce,
    busio_seq_if.master  io_bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP,
        S_RD,
        S_RD_END,
        S_RMW_WAIT,
        S_WR,
        S_WR_END,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LD   = TMO_W'(TMO);
    localparam logic [1:0]       SETUP_LD = (SETUP > 0) ? 2'(SETUP - 1) : 2'd0;
    localparam bit               NO_SETUP = (SETUP == 0);

    state_t             r_state, w_state_nxt;
    logic [TMO_W-1:0]   r_cnt, w_cnt_nxt;
    logic [1:0]         r_scnt, w_scnt_nxt;
    logic               r_b, w_b_nxt;
    logic               r_rmw, w_rmw_nxt;
    logic               r_wr, w_wr_nxt;
    logic               w_tmo;
    logic               w_sync;

    assign w_tmo = (r_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= TMO_LD;
            r_scnt  <= '0;
            r_b     <= 1'b0;
            r_rmw   <= 1'b0;
            r_wr    <= 1'b0;
        end else if (i_ce) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_scnt  <= w_scnt_nxt;
            r_b     <= w_b_nxt;
            r_rmw   <= w_rmw_nxt;
            r_wr    <= w_wr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_scnt_nxt  = r_scnt;
        w_b_nxt     = r_b;
        w_rmw_nxt   = r_rmw;
        w_wr_nxt    = r_wr;

        case (r_state)
            S_IDLE: begin
                if (io_bus.dati || io_bus.dato) begin
                    // dati wins; a write never carries the rmw flag
                    w_b_nxt    = io_bus.b;
                    w_wr_nxt   = ~io_bus.dati;
                    w_rmw_nxt  = io_bus.dati & io_bus.rmw;
                    w_scnt_nxt = SETUP_LD;
                    if (NO_SETUP)
                        w_state_nxt = io_bus.dati ? S_RD : S_WR;
                    else
                        w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_scnt == '0)
                    w_state_nxt = r_wr ? S_WR : S_RD;
                else
                    w_scnt_nxt = r_scnt - 2'd1;
            end
            S_RD, S_WR: begin
                if (io_bus.rply)
                    w_state_nxt = (r_state == S_RD) ? S_RD_END : S_WR_END;
                else if (w_tmo)
                    w_state_nxt = S_ERR;
                else
                    w_cnt_nxt = r_cnt - 1'b1;
            end
            S_RD_END, S_WR_END: begin
                if (!io_bus.rply)
                    w_state_nxt = (r_state == S_RD_END && r_rmw) ? S_RMW_WAIT : S_DONE;
                else if (w_tmo)
                    w_state_nxt = S_ERR;
                else
                    w_cnt_nxt = r_cnt - 1'b1;
            end
            S_RMW_WAIT: begin
                if (io_bus.dato)
                    w_state_nxt = S_WR;
            end
            S_DONE, S_ERR: w_state_nxt = S_IDLE;
            default:       w_state_nxt = S_IDLE;
        endcase

        // Every state change reloads the timeout, so each waiting phase starts fresh
        if (w_state_nxt != r_state)
            w_cnt_nxt = TMO_LD;
    end

    assign w_sync = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);

    assign io_bus.sync     = w_sync;
    assign io_bus.bsy      = w_sync;
    assign io_bus.din      = (r_state == S_RD);
    assign io_bus.dout     = (r_state == S_WR);
    assign io_bus.wtbt     = r_b & w_sync;
    assign io_bus.complete = (r_state == S_DONE) || (r_state == S_ERR);
    assign io_bus.berror   = (r_state == S_ERR);
    assign io_bus.latch    = (r_state == S_RD) && io_bus.rply && i_ce && !i_reset;

endmodule

// File: tb/tb_busio_seq.sv
// Directed bench for busio_seq: stimulus pushes expected cycle summaries,
// a negedge monitor accumulates strobe activity and checks it at each cycle end.
module tb_busio_seq;

    logic clk = 1'b0;
    logic reset;
    logic ce;
    bit   ce_half = 1'b0;

    always #5 clk = ~clk;

    busio_seq_if bus();

    busio_seq #(
        .SETUP (1),
        .TMO_W (6),
        .TMO   (63)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_ce    (ce),
        .io_bus  (bus.master)
    );

    typedef struct {
        string name;
        int    sync_n;
        int    din_n;
        int    dout_n;
        int    latch_n;
        int    wtbt_n;
        int    berr;
        int    din_first;
        int    din_last;
        int    latch_rel;
        int    cmp_rel;
        int    lead;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // monitor accumulators
    int s_sync, s_din, s_dout, s_latch, s_wtbt, s_wtbt_off, s_berr_stray, s_gap;
    int rel, din_first, din_last, latch_rel, lead;
    bit started, prev_cmp;

    task automatic chk(input string nm, input int act, input int exp);
        if (exp < 0) return;
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input int sy, input int di, input int dou,
                        input int la, input int wt, input int be, input int df,
                        input int dl, input int lr, input int cr, input int ld);
        exp_t e;
        e.name = nm; e.sync_n = sy; e.din_n = di; e.dout_n = dou; e.latch_n = la;
        e.wtbt_n = wt; e.berr = be; e.din_first = df; e.din_last = dl;
        e.latch_rel = lr; e.cmp_rel = cr; e.lead = ld;
        q.push_back(e);
    endtask

    task automatic clr();
        s_sync = 0; s_din = 0; s_dout = 0; s_latch = 0; s_wtbt = 0;
        s_wtbt_off = 0; s_berr_stray = 0; s_gap = 0;
        rel = 0; din_first = -1; din_last = -1; latch_rel = -1;
    endtask

    initial begin
        clr();
        lead = 0;
        started = 1'b0;
        prev_cmp = 1'b0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            clr();
            lead = 0;
            started = 1'b0;
            prev_cmp = 1'b0;
        end else begin
            if (bus.wtbt && !bus.sync) s_wtbt_off++;
            if (bus.berror && !bus.complete) s_berr_stray++;
            if (bus.complete && !prev_cmp) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_complete: got complete=1 berror=%0d, required no cycle end",
                             bus.berror);
                end else begin
                    e = q.pop_front();
                    chk({e.name, ".sync_cycles"}, s_sync, e.sync_n);
                    chk({e.name, ".din_cycles"}, s_din, e.din_n);
                    chk({e.name, ".dout_cycles"}, s_dout, e.dout_n);
                    chk({e.name, ".latch_pulses"}, s_latch, e.latch_n);
                    chk({e.name, ".wtbt_cycles"}, s_wtbt, e.wtbt_n);
                    chk({e.name, ".berror"}, int'(bus.berror), e.berr);
                    chk({e.name, ".sync_at_complete"}, int'(bus.sync), 0);
                    chk({e.name, ".sync_gaps"}, s_gap, 0);
                    chk({e.name, ".wtbt_without_sync"}, s_wtbt_off, 0);
                    chk({e.name, ".berror_without_complete"}, s_berr_stray, 0);
                    chk({e.name, ".din_first"}, din_first, e.din_first);
                    chk({e.name, ".din_last"}, din_last, e.din_last);
                    chk({e.name, ".latch_pos"}, latch_rel, e.latch_rel);
                    chk({e.name, ".complete_pos"}, rel + 1, e.cmp_rel);
                    chk({e.name, ".idle_before"}, lead, e.lead);
                end
                clr();
                started = 1'b0;
                lead = 0;
            end else if (!bus.complete) begin
                if (bus.sync) begin
                    if (!started) begin
                        started = 1'b1;
                        rel = 0;
                    end else begin
                        rel++;
                    end
                    s_sync++;
                    if (bus.wtbt) s_wtbt++;
                    if (bus.din) begin
                        if (din_first < 0) din_first = rel;
                        din_last = rel;
                        s_din++;
                    end
                    if (bus.dout) s_dout++;
                end else if (started) begin
                    s_gap++;
                end else begin
                    lead++;
                end
                if (bus.latch) begin
                    s_latch++;
                    latch_rel = rel;
                end
            end
            prev_cmp = bus.complete;
        end
    end

    initial begin
        ce = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ce = ce_half ? ~ce : 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // 0: din, 1: dout, 2: complete, other: scoreboard drained
    task automatic wait_sig(input int which, input string nm, input int budget);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < budget; k++) begin
            case (which)
                0:       hit = bus.din;
                1:       hit = bus.dout;
                2:       hit = bus.complete;
                default: hit = (q.size() == 0);
            endcase
            if (hit) break;
            tick(1);
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: event absent after %0d clk, required within budget", nm, budget);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".sync"}, int'(bus.sync), 0);
        chk({nm, ".din"}, int'(bus.din), 0);
        chk({nm, ".dout"}, int'(bus.dout), 0);
        chk({nm, ".wtbt"}, int'(bus.wtbt), 0);
        chk({nm, ".bsy"}, int'(bus.bsy), 0);
        chk({nm, ".latch"}, int'(bus.latch), 0);
        chk({nm, ".complete"}, int'(bus.complete), 0);
        chk({nm, ".berror"}, int'(bus.berror), 0);
    endtask

    initial begin
        int stray;
        reset = 1'b1;
        bus.dati = 1'b0; bus.dato = 1'b0; bus.rmw = 1'b0; bus.b = 1'b0; bus.rply = 1'b0;
        tick(3);
        chk_all_zero("reset");
        reset = 1'b0;
        tick(2);
        chk_all_zero("idle");

        // basic read with one setup cycle; rply high at cycles 4..5
        push("rd_basic", 6, 3, 0, 1, 0, 0, 1, 3, 3, 6, -1);
        bus.dati = 1'b1; bus.b = 1'b0; bus.rmw = 1'b0;
        tick(1);
        bus.dati = 1'b0;
        tick(3);
        bus.rply = 1'b1;
        tick(2);
        bus.rply = 1'b0;
        wait_sig(3, "rd_basic", 30);
        tick(2);

        // byte write with no reply: 64 dout cycles then ERR
        push("wr_tmo", 65, 0, 64, 0, 65, 1, -1, -1, -1, 65, -1);
        bus.dato = 1'b1; bus.b = 1'b1;
        tick(2);
        bus.dato = 1'b0;
        wait_sig(3, "wr_tmo", 120);
        bus.b = 1'b0;
        tick(2);

        // read-modify-write; dato raised 5 cycles after rply falls
        push("rmw", 11, 1, 1, 1, 0, 0, 1, 1, 1, 11, -1);
        bus.dati = 1'b1; bus.rmw = 1'b1;
        wait_sig(0, "rmw_din", 20);
        bus.rply = 1'b1;
        bus.dati = 1'b0;
        bus.rmw = 1'b0;
        tick(2);
        bus.rply = 1'b0;
        tick(5);
        bus.dato = 1'b1;
        wait_sig(1, "rmw_dout", 20);
        bus.rply = 1'b1;
        bus.dato = 1'b0;
        tick(1);
        bus.rply = 1'b0;
        wait_sig(3, "rmw", 20);
        tick(2);

        // clock enable every second clk, read with no reply
        push("rd_ce_half", 130, 128, 0, 0, 0, 1, 2, 129, -1, 130, -1);
        ce_half = 1'b1;
        bus.dati = 1'b1;
        wait_sig(0, "ce_half_din", 20);
        bus.dati = 1'b0;
        wait_sig(3, "rd_ce_half", 300);
        tick(4);
        ce_half = 1'b0;
        tick(3);

        // reset in the middle of a write: strobes drop, no cycle end
        bus.dato = 1'b1; bus.b = 1'b1;
        wait_sig(1, "rst_wr_dout", 20);
        bus.dato = 1'b0;
        bus.b = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
        chk_all_zero("mid_reset");
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.complete || bus.berror) stray++;
            tick(1);
        end
        chk("mid_reset.end_pulses", stray, 0);
        push("rd_after_rst", 3, 1, 0, 1, 0, 0, 1, 1, 1, 3, -1);
        bus.dati = 1'b1;
        wait_sig(0, "after_rst_din", 20);
        bus.rply = 1'b1;
        bus.dati = 1'b0;
        tick(1);
        bus.rply = 1'b0;
        wait_sig(3, "rd_after_rst", 20);
        tick(2);

        // dati and dato together: read first, write starts from the next IDLE
        push("rd_of_both", 3, 1, 0, 1, 0, 0, 1, 1, 1, 3, -1);
        push("wr_after_rd", 3, 0, 1, 0, 0, 0, -1, -1, -1, 3, 1);
        bus.dati = 1'b1; bus.dato = 1'b1;
        wait_sig(0, "both_din", 20);
        bus.rply = 1'b1;
        tick(1);
        bus.rply = 1'b0;
        wait_sig(2, "both_done", 20);
        bus.dati = 1'b0;
        wait_sig(1, "both_dout", 20);
        bus.rply = 1'b1;
        tick(1);
        bus.rply = 1'b0;
        bus.dato = 1'b0;
        wait_sig(3, "both", 20);
        tick(5);

        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
